// File: rtl/rlbp_pkg.sv
// Shared definitions for the RLBP stream engine: register map, control/status
// bit positions, FSM states and the rotation-normalisation helper.
package rlbp_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_PIX    = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_ROT   = 2;
    localparam int CTRL_IE    = 3;
    localparam int CTRL_CLR   = 4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_RV      = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_EMPTY   = 3;
    localparam int STAT_OVF_PIX = 4;
    localparam int STAT_OVF_RES = 5;

    localparam int WIN_LEN = 9;
    // Magnitudes are carried at the widest supported pixel width.
    localparam int MAG_W   = 12;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, SHIFT} state_t;
    typedef logic [MAG_W-1:0] mag_t;

    // Rotate raw right by the index of the largest |n_i - c| (lowest index wins ties).
    function automatic logic [7:0] rot_code(input logic [7:0] raw,
                                            input mag_t [7:0] mags,
                                            input logic rot_en);
        logic [2:0] k;
        logic [3:0] sh;
        mag_t       best;
        k    = 3'd0;
        best = mags[0];
        for (int i = 1; i < 8; i++) begin
            if (mags[i] > best) begin
                best = mags[i];
                k    = 3'(i);
            end
        end
        sh = 4'd8 - {1'b0, k};
        return rot_en ? ((raw >> k) | (raw << sh)) : raw;
    endfunction

endpackage

// File: rtl/rlbp_pix_fifo.sv
// Pixel FIFO with show-ahead read; a full FIFO still accepts a push when a pop
// happens in the same cycle.
module rlbp_pix_fifo #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [PIX_W-1:0]         push_data,
    input  logic                     pop,
    output logic [PIX_W-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];
    assign pop_ok   = pop & ~empty & ~flush;
    assign push_ok  = push & (~full | pop_ok) & ~flush;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rlbp_stream_engine.sv
// Wishbone-controlled LBP/RLBP engine: pixels stream in through a FIFO, each
// 9-pixel window yields an 8-bit code held in RESULT and shifted out LSB first.
module rlbp_stream_engine
    import rlbp_pkg::*;
#(
    parameter int         PIX_W      = 8,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [3:0] BASE_NIB   = 4'h3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        ser_data_o,
    output logic        ser_valid_o,
    output logic        busy_o,
    output logic        irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             ack_reg;
    logic [31:0]      dat_reg;
    logic             auto_reg, rot_en_reg, ie_reg;
    logic             ovf_pix_reg, ovf_res_reg, rv_reg;
    logic [7:0]       code_reg;
    logic [7:0]       ser_sh_reg;
    logic             ser_valid_reg;
    logic [3:0]       load_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    state_t           state_reg;
    logic [PIX_W-1:0] win_reg [WIN_LEN];

    logic             wb_valid, wb_acc, wb_wr, wb_rd;
    logic [1:0]       reg_sel;
    logic             wr_ctrl, wr_status, start_cmd, clr_cmd, pix_push, pix_drop, rd_result;
    logic             fifo_pop, fifo_full, fifo_empty, win_ready;
    logic [PIX_W-1:0] fifo_rd;
    logic [CW-1:0]    fifo_count;
    logic [7:0]       raw_bits;
    mag_t [7:0]       mags;
    logic [7:0]       new_code;
    logic [31:0]      rd_data;
    logic             unused_bits;

    assign unused_bits = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

    // A held strobe cannot re-trigger in the ack cycle, so acks never run back to back.
    assign wb_valid  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIB);
    assign wb_acc    = wb_valid & ~ack_reg;
    assign wb_wr     = wb_acc & wbs_we_i & wbs_sel_i[0];
    assign wb_rd     = wb_acc & ~wbs_we_i;
    assign reg_sel   = wbs_adr_i[3:2];
    assign wr_ctrl   = wb_wr & (reg_sel == REG_CTRL);
    assign wr_status = wb_wr & (reg_sel == REG_STATUS);
    assign start_cmd = wr_ctrl & wbs_dat_i[CTRL_START];
    assign clr_cmd   = wr_ctrl & wbs_dat_i[CTRL_CLR];
    assign pix_push  = wb_wr & (reg_sel == REG_PIX);
    assign rd_result = wb_rd & (reg_sel == REG_RESULT);

    assign fifo_pop  = (state_reg == LOAD) & ~fifo_empty;
    assign pix_drop  = pix_push & fifo_full & ~fifo_pop;
    assign win_ready = fifo_count >= CW'(WIN_LEN);

    rlbp_pix_fifo #(
        .PIX_W (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (clr_cmd),
        .push      (pix_push),
        .push_data (wbs_dat_i[PIX_W-1:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // win_reg[0] is the centre, win_reg[1..8] are n0..n7.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cmp
            assign raw_bits[gi] = (win_reg[gi+1] >= win_reg[0]);
            assign mags[gi]     = raw_bits[gi] ? mag_t'(win_reg[gi+1] - win_reg[0])
                                               : mag_t'(win_reg[0] - win_reg[gi+1]);
        end
    endgenerate

    assign new_code = rot_code(raw_bits, mags, rot_en_reg);

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_data[CTRL_AUTO] = auto_reg;
                rd_data[CTRL_ROT]  = rot_en_reg;
                rd_data[CTRL_IE]   = ie_reg;
            end
            REG_STATUS: begin
                rd_data[STAT_BUSY]    = (state_reg != IDLE);
                rd_data[STAT_RV]      = rv_reg;
                rd_data[STAT_FULL]    = fifo_full;
                rd_data[STAT_EMPTY]   = fifo_empty;
                rd_data[STAT_OVF_PIX] = ovf_pix_reg;
                rd_data[STAT_OVF_RES] = ovf_res_reg;
                rd_data[15:8]         = 8'(fifo_count);
            end
            REG_RESULT: begin
                rd_data[8]   = rv_reg;
                rd_data[7:0] = code_reg;
            end
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (fifo_pop) begin
            win_reg[load_cnt_reg] <= fifo_rd;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_reg     <= 1'b0;
            dat_reg     <= '0;
            auto_reg    <= 1'b0;
            rot_en_reg  <= 1'b0;
            ie_reg      <= 1'b0;
            ovf_pix_reg <= 1'b0;
        end else begin
            ack_reg <= wb_acc;
            dat_reg <= wb_rd ? rd_data : '0;
            if (wr_ctrl) begin
                auto_reg   <= wbs_dat_i[CTRL_AUTO];
                rot_en_reg <= wbs_dat_i[CTRL_ROT];
                ie_reg     <= wbs_dat_i[CTRL_IE];
            end
            if (clr_cmd) begin
                ovf_pix_reg <= 1'b0;
            end else if (pix_drop) begin
                ovf_pix_reg <= 1'b1;
            end else if (wr_status & wbs_dat_i[STAT_OVF_PIX]) begin
                ovf_pix_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg     <= IDLE;
            load_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            code_reg      <= '0;
            rv_reg        <= 1'b0;
            ovf_res_reg   <= 1'b0;
            ser_sh_reg    <= '0;
            ser_valid_reg <= 1'b0;
        end else if (clr_cmd) begin
            state_reg     <= IDLE;
            load_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            rv_reg        <= 1'b0;
            ovf_res_reg   <= 1'b0;
            ser_sh_reg    <= '0;
            ser_valid_reg <= 1'b0;
        end else begin
            if (rd_result) rv_reg <= 1'b0;
            if (wr_status & wbs_dat_i[STAT_OVF_RES]) ovf_res_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_cmd | (auto_reg & win_ready)) begin
                        state_reg    <= LOAD;
                        load_cnt_reg <= '0;
                    end
                end
                LOAD: begin
                    if (fifo_pop) begin
                        if (load_cnt_reg == 4'd8) state_reg <= COMPUTE;
                        else load_cnt_reg <= load_cnt_reg + 4'd1;
                    end
                end
                COMPUTE: begin
                    code_reg      <= new_code;
                    rv_reg        <= 1'b1;
                    if (rv_reg & ~rd_result) ovf_res_reg <= 1'b1;
                    ser_sh_reg    <= new_code;
                    ser_valid_reg <= 1'b1;
                    bit_cnt_reg   <= '0;
                    state_reg     <= SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt_reg == 3'd7) begin
                        ser_valid_reg <= 1'b0;
                        ser_sh_reg    <= '0;
                        load_cnt_reg  <= '0;
                        state_reg     <= (auto_reg & win_ready) ? LOAD : IDLE;
                    end else begin
                        ser_sh_reg  <= ser_sh_reg >> 1;
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o   = ack_reg;
    assign wbs_dat_o   = dat_reg;
    assign ser_data_o  = ser_sh_reg[0];
    assign ser_valid_o = ser_valid_reg;
    assign busy_o      = (state_reg != IDLE);
    assign irq_o       = (rv_reg & ie_reg) | ovf_pix_reg | ovf_res_reg;

endmodule

// File: tb/tb_rlbp_stream_engine.sv
// Scoreboard bench for rlbp_stream_engine: stimulus queues expected WB read data
// and serial codes; two monitors pop and compare as the DUT presents them.
module tb_rlbp_stream_engine;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_STATUS = 32'h3000_0004;
    localparam logic [31:0] A_PIX    = 32'h3000_0008;
    localparam logic [31:0] A_RESULT = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic        ser_data, ser_valid, busy, irq;

    int checks = 0;
    int errors = 0;

    logic [32:0] wb_q[$];
    string       wb_name_q[$];
    logic [7:0]  ser_q[$];
    int          ser_cnt = 0;
    logic [7:0]  ser_acc;

    int gw[9];
    int w1[9] = '{100, 90, 110, 100, 50, 120, 100, 99, 101};
    int wa[9];
    int wb[9];

    always #5 clk = ~clk;

    rlbp_stream_engine #(.PIX_W(8), .FIFO_DEPTH(16), .BASE_NIB(4'h3)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_w),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_r),
        .ser_data_o  (ser_data),
        .ser_valid_o (ser_valid),
        .busy_o      (busy),
        .irq_o       (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: LBP bits, argmax of |n_i - c| (first max wins), optional rotate right.
    function automatic logic [7:0] ref_code(input int w[9], input bit rot);
        int raw, k, best, d;
        raw = 0; k = 0; best = -1;
        for (int i = 0; i < 8; i++) begin
            if (w[i+1] >= w[0]) raw += (1 << i);
            d = w[i+1] - w[0];
            if (d < 0) d = -d;
            if (d > best) begin
                best = d;
                k = i;
            end
        end
        if (rot) raw = ((raw >> k) | (raw << (8 - k))) & 255;
        return raw[7:0];
    endfunction

    task automatic gen_window();
        int c, v;
        c = $urandom_range(0, 255);
        gw[0] = c;
        for (int i = 1; i < 9; i++) begin
            if ($urandom_range(0, 1) == 1) v = $urandom_range(0, 255);
            else v = c + $urandom_range(0, 6) - 3;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            gw[i] = v;
        end
    endtask

    task automatic wb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp, input string nm);
        int n;
        wb_q.push_back({~wr, exp});
        wb_name_q.push_back(nm);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat_w = d; sel = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 20);
        if (!ack) begin
            checks++;
            errors++;
            $display("FAIL %s: no ack within %0d cycles", nm, n);
            void'(wb_q.pop_back());
            void'(wb_name_q.pop_back());
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        wb_xfer(1'b1, a, d, 32'h0, "write");
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        wb_xfer(1'b0, a, 32'h0, exp, nm);
    endtask

    task automatic push_window(input int w[9]);
        for (int i = 0; i < 9; i++) wb_write(A_PIX, 32'(w[i]));
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((ser_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL %s: engine still busy after %0d cycles", nm, n);
        end
    endtask

    // WB monitor: every ack consumes one scoreboard entry; reads compare data.
    initial begin
        logic [32:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (!rst && ack) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack=1 expected 0 (data 0x%0h)", dat_r);
                end else begin
                    e  = wb_q.pop_front();
                    nm = wb_name_q.pop_front();
                    if (e[32]) begin
                        chk(nm, dat_r, e[31:0]);
                        $display("read %s data 0x%0h", nm, dat_r);
                    end
                end
            end
        end
    end

    // Serial monitor: assembles 8 contiguous LSB-first bits and compares.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                ser_cnt = 0;
            end else if (ser_valid) begin
                ser_acc[ser_cnt] = ser_data;
                ser_cnt++;
                if (ser_cnt == 8) begin
                    if (ser_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_burst: got code 0x%0h expected none", ser_acc);
                    end else begin
                        chk("serial_code", {24'h0, ser_acc}, {24'h0, ser_q.pop_front()});
                        $display("serial burst code 0x%0h", ser_acc);
                    end
                    ser_cnt = 0;
                end
            end else if (ser_cnt != 0) begin
                checks++;
                errors++;
                $display("FAIL serial_burst_len: got %0d bits expected 8", ser_cnt);
                ser_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cycles;
        int         got;
        logic [3:0] pat;
        logic [7:0] code, code_a, code_b;
        bit         rot;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
        repeat (3) @(negedge clk);
        chk("reset_ser_valid", {31'h0, ser_valid}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_ack", {31'h0, ack}, 32'h0);
        rst = 1'b0;
        wb_read(A_STATUS, 32'h08, "reset_status");
        wb_read(A_RESULT, 32'h0, "reset_result");
        wb_read(A_CTRL, 32'h0, "reset_ctrl");

        // Plain LBP with interrupt enabled.
        push_window(w1);
        ser_q.push_back(8'hB6);
        wb_write(A_CTRL, 32'h9);
        cycles = 0;
        while (!ser_valid && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        chk("start_to_first_bit", 32'(cycles), 32'd10);
        wait_done("t1");
        chk("t1_irq", {31'h0, irq}, 32'h1);
        wb_read(A_RESULT, 32'h1B6, "t1_result");
        chk("t1_irq_after_read", {31'h0, irq}, 32'h0);
        wb_read(A_STATUS, 32'h08, "t1_status");

        // Rotation-normalised.
        push_window(w1);
        ser_q.push_back(8'hD6);
        wb_write(A_CTRL, 32'h5);
        wait_done("t2");
        wb_read(A_RESULT, 32'h1D6, "t2_result");
        wb_read(A_STATUS, 32'h08, "t2_status");

        // FIFO overflow with no start.
        wb_write(A_CTRL, 32'h0);
        for (int i = 0; i < 17; i++) wb_write(A_PIX, 32'(i));
        wb_read(A_STATUS, 32'h1014, "t3_status_full");
        chk("t3_irq_ovf", {31'h0, irq}, 32'h1);
        wb_write(A_STATUS, 32'h10);
        wb_read(A_STATUS, 32'h1004, "t3_status_cleared");
        wb_write(A_CTRL, 32'h10);
        wb_read(A_STATUS, 32'h08, "t3_status_clr");

        // Auto mode, two windows back to back, RESULT not read in between.
        gen_window(); wa = gw;
        gen_window(); wb = gw;
        code_a = ref_code(wa, 1'b0);
        code_b = ref_code(wb, 1'b0);
        ser_q.push_back(code_a);
        ser_q.push_back(code_b);
        wb_write(A_CTRL, 32'h2);
        push_window(wa);
        push_window(wb);
        wait_done("t4");
        wb_read(A_STATUS, 32'h2A, "t4_status_ovf_res");
        chk("t4_irq", {31'h0, irq}, 32'h1);
        wb_write(A_STATUS, 32'h20);
        wb_write(A_CTRL, 32'h0);
        wb_read(A_RESULT, 32'h100 | 32'(code_b), "t4_result");
        wb_read(A_STATUS, 32'h08, "t4_status_final");

        // Reset in the middle of a serial burst.
        gen_window();
        ser_q.push_back(ref_code(gw, 1'b0));
        push_window(gw);
        wb_write(A_CTRL, 32'h1);
        cycles = 0;
        while (!ser_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        chk("t5_burst_started", {31'h0, ser_valid}, 32'h1);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        ser_q.delete();
        #1;
        chk("t5_ser_valid", {31'h0, ser_valid}, 32'h0);
        chk("t5_busy", {31'h0, busy}, 32'h0);
        chk("t5_ack", {31'h0, ack}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wb_read(A_STATUS, 32'h08, "t5_status");
        wb_read(A_CTRL, 32'h0, "t5_ctrl");

        // Foreign address: no ack.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h2000_000C; sel = 4'hF;
        got = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack) got++;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("foreign_no_ack", 32'(got), 32'h0);

        // Held strobe on PIX_IN read: single-cycle acks, never back to back, data 0.
        wb_q.push_back({1'b1, 32'h0}); wb_name_q.push_back("pix_in_read");
        wb_q.push_back({1'b1, 32'h0}); wb_name_q.push_back("pix_in_read");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_PIX; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("ack_pattern", {28'h0, pat}, 32'h5);

        // Randomised windows with random rotation setting.
        for (int r = 0; r < 10; r++) begin
            gen_window();
            rot  = 1'($urandom_range(0, 1));
            code = ref_code(gw, rot);
            ser_q.push_back(code);
            push_window(gw);
            wb_write(A_CTRL, rot ? 32'h5 : 32'h1);
            wait_done("rand");
            wb_read(A_RESULT, 32'h100 | 32'(code), "rand_result");
        end
        wb_read(A_STATUS, 32'h08, "final_status");

        repeat (3) @(negedge clk);
        if (wb_q.size() != 0 || ser_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d wb and %0d serial pending expected 0",
                     wb_q.size(), ser_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rlbp_stream_engine.md
Name: rlbp_stream_engine

Overview:
Wishbone-controlled successor to the single-shot RLBP macro. Host pushes 3x3 pixel windows through a pixel FIFO. The engine computes the 8-bit local binary pattern, optionally rotation-normalised (RLBP). Each code is held in a readable result register and shifted out serially, with done/overflow status, IRQ, and a continuous (auto) mode.

Parameters:
PIX_W, 8, pixel width in bits (4..12)
FIFO_DEPTH, 16, pixel FIFO entries; power of 2, >= 9
BASE_NIB, 4'h3, required value of wbs_adr_i[31:28] for the block to respond

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
wbs_stb_i  in  1  WB strobe
wbs_cyc_i  in  1  WB cycle
wbs_we_i  in  1  WB write enable
wbs_sel_i  in  4  WB byte selects
wbs_adr_i  in  32  WB address; [3:2] selects the register
wbs_dat_i  in  32  WB write data
wbs_ack_o  out  1  WB acknowledge
wbs_dat_o  out  32  WB read data
ser_data_o  out  1  serial code bit, LSB first
ser_valid_o  out  1  high while ser_data_o carries a code bit
busy_o  out  1  FSM not in IDLE
irq_o  out  1  level: (result_valid & CTRL.ie) | sticky overflow

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE, CTRL=0, result=0, flags=0.
- WB access: valid = cyc & stb & (adr[31:28]==BASE_NIB).
  - ack is a 1-cycle pulse on the cycle after valid; it is never asserted on two consecutive cycles.
  - Writes require wbs_sel_i[0]. Unmapped reads return 0.
- Registers (by adr[3:2]):
  - 0 CTRL (RW): [0] start (self-clearing), [1] auto, [2] rot_en, [3] ie, [4] clr (self-clearing).
  - 1 STATUS (RO): [0] busy, [1] result_valid, [2] fifo_full, [3] fifo_empty, [4] ovf_pix (sticky), [5] ovf_res (sticky), [15:8] fifo_count. Writing 1 to bit 4 or 5 clears that flag.
  - 2 PIX_IN (WO): push wbs_dat_i[PIX_W-1:0]. If the FIFO is full, the push is dropped and ovf_pix is set. Reads return 0.
  - 3 RESULT (RO): {23'b0, result_valid, code[7:0]}. Reading clears result_valid; ack'ing the read counts as the pop.
- Window order: 9 pixels per window. Word 0 is the centre c; words 1..8 are neighbours n0..n7, clockwise from top-left.
- FSM IDLE -> LOAD: on start, or when auto=1 and FIFO count >= 9. A start while busy is ignored.
- LOAD: pops one pixel per cycle while the FIFO is non-empty; stalls on empty. Exits after the 9th pop.
- COMPUTE (1 cycle):
  - b_i = (n_i >= c), unsigned; raw = {b7..b0}.
  - k = index of max |n_i - c|; ties go to the lowest index.
  - code = rot_en ? ror(raw, k) : raw.
  - The code is latched into RESULT at the end of the cycle and result_valid is set. If result_valid was already 1, ovf_res is set and the old code is overwritten.
- SHIFT: 8 cycles, ser_valid_o=1, ser_data_o = code[i] for i = 0..7.
- Next state after SHIFT: LOAD if auto=1 and count >= 9, else IDLE.
- Latency: last pop -> RESULT valid in 1 cycle; the first serial bit appears in the cycle after COMPUTE.
- clr: empties the FIFO, forces IDLE, drops ser_valid_o, and clears result_valid and both sticky flags. CTRL auto/rot_en/ie keep their written values.
- Async reset mid-window aborts immediately. A partial window is discarded.
- A simultaneous FIFO push (WB) and pop (LOAD) in the same cycle is allowed; count is unchanged, and a full FIFO accepts the push.

Decomposition:
- Package rlbp_pkg: register offsets, CTRL/STATUS bit indices, FSM state enum (IDLE, LOAD, COMPUTE, SHIFT), and the rotate/argmax helper function.
- One sub-module: rlbp_pix_fifo. Synchronous FIFO, PIX_W x FIFO_DEPTH, with push, pop, full, empty and count, and async reset.

Test Plan:
1. Window c=100, n=[90,110,100,50,120,100,99,101], rot_en=0, start -> raw 0xB6 in RESULT; serial bits 0,1,1,0,1,1,0,1; irq_o=1 when ie=1.
2. Same window with rot_en=1 -> k=3, RESULT=0xD6; reading RESULT returns 0x1D6, then STATUS[1]=0.
3. Push 17 pixels with FIFO_DEPTH=16 and no start -> STATUS.ovf_pix=1, fifo_count=16, fifo_full=1. Write 1 to STATUS[4] -> flag clears.
4. auto=1, push two windows back-to-back without reading RESULT -> two serial bursts; ovf_res=1; RESULT holds the second code.
5. Assert wb_rst_i during SHIFT bit 4 -> ser_valid_o, busy_o, and wbs_ack_o are 0 in the same cycle; after release STATUS=0x08 (empty).
6. WB read of an address with adr[31:28]=4'h2 -> no ack. Read of adr[3:2]=2 -> data 0, ack exactly one cycle.
